// File: rtl/sensor_monitor_multi_pkg.sv
// Shared types and helpers for the multi-channel sensor monitor and its classifier.
package sensor_mon_pkg;

    typedef enum logic [1:0] {IDLE, ACCUM, COMPUTE, CHECK} state_t;

    localparam logic [2:0] LVL_OK = 3'd0;
    localparam logic [2:0] LVL_1  = 3'd1;
    localparam logic [2:0] LVL_2  = 3'd2;
    localparam logic [2:0] LVL_3  = 3'd3;
    localparam logic [2:0] LVL_4  = 3'd4;

    // Channel index width; a single channel still needs one bit.
    function automatic int ch_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sensor_monitor_multi_if.sv
// Sample stream in, window result out, between the sensor mux and the monitor.
interface sensor_monitor_multi_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8
);
    import sensor_mon_pkg::*;
    localparam int CH_W = ch_width(NUM_CH);

    logic              sample_valid;
    logic [DATA_W-1:0] sample_data;
    logic [CH_W-1:0]   sample_ch;
    logic              busy;
    logic              result_valid;
    logic [CH_W-1:0]   result_ch;
    logic [DATA_W-1:0] result_avg;
    logic [2:0]        fault_level;
    logic              first_window;

    modport master (
        output sample_valid, sample_data, sample_ch,
        input  busy, result_valid, result_ch, result_avg, fault_level, first_window
    );

    modport slave (
        input  sample_valid, sample_data, sample_ch,
        output busy, result_valid, result_ch, result_avg, fault_level, first_window
    );

endinterface

// File: rtl/sensor_monitor_multi_fault_classifier.sv
// Maps a deviation onto severity 0..4; the highest threshold reached wins.
module fault_classifier
    import sensor_mon_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] dev,
    input  logic [DATA_W-1:0] thr1,
    input  logic [DATA_W-1:0] thr2,
    input  logic [DATA_W-1:0] thr3,
    input  logic [DATA_W-1:0] thr4,
    output logic [2:0]        level
);

    always_comb begin
        level = LVL_OK;
        if      (dev >= thr4) level = LVL_4;
        else if (dev >= thr3) level = LVL_3;
        else if (dev >= thr2) level = LVL_2;
        else if (dev >= thr1) level = LVL_1;
    end

endmodule

// File: rtl/sensor_monitor_multi.sv
// N-channel windowed averager with per-channel baseline, fault grading and sticky alerts.
module sensor_monitor_multi
    import sensor_mon_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int DATA_W   = 8,
    parameter int AVG_LOG2 = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ena,
    sensor_monitor_multi_if.slave mon,
    input  logic [DATA_W-1:0]   thr1,
    input  logic [DATA_W-1:0]   thr2,
    input  logic [DATA_W-1:0]   thr3,
    input  logic [DATA_W-1:0]   thr4,
    input  logic [NUM_CH-1:0]   alert_clr,
    output logic [NUM_CH-1:0]   alert_mask,
    output logic                alert
);

    localparam int CH_W  = ch_width(NUM_CH);
    localparam int ACC_W = DATA_W + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] WIN = CNT_W'(1 << AVG_LOG2);

    state_t                         state;
    logic [ACC_W-1:0]               acc;
    logic [CNT_W-1:0]               cnt;
    logic [CH_W-1:0]                win_ch;
    logic [DATA_W-1:0]              avg, dev;
    logic [NUM_CH-1:0][DATA_W-1:0]  baseline;
    logic [NUM_CH-1:0]              base_set;

    logic                           rv_q;
    logic [CH_W-1:0]                res_ch;
    logic [DATA_W-1:0]              res_avg;
    logic [2:0]                     res_lvl;
    logic                           res_first;

    logic                           accept;
    logic [ACC_W-1:0]               sample_ext;
    logic [CNT_W-1:0]               cnt_inc;
    logic [DATA_W-1:0]              avg_nxt, base_cur, dev_nxt;
    logic [2:0]                     cls_lvl;

    assign accept     = ena & mon.sample_valid & ((state == IDLE) | (state == ACCUM));
    assign sample_ext = ACC_W'(mon.sample_data);
    assign cnt_inc    = cnt + 1'b1;
    assign avg_nxt    = DATA_W'(acc >> AVG_LOG2);
    assign base_cur   = baseline[win_ch];
    assign dev_nxt    = (avg_nxt >= base_cur) ? (avg_nxt - base_cur) : (base_cur - avg_nxt);

    fault_classifier #(.DATA_W(DATA_W)) u_cls (
        .dev   (dev),
        .thr1  (thr1),
        .thr2  (thr2),
        .thr3  (thr3),
        .thr4  (thr4),
        .level (cls_lvl)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            acc        <= '0;
            cnt        <= '0;
            win_ch     <= '0;
            avg        <= '0;
            dev        <= '0;
            baseline   <= '0;
            base_set   <= '0;
            alert_mask <= '0;
            rv_q       <= 1'b0;
            res_ch     <= '0;
            res_avg    <= '0;
            res_lvl    <= LVL_OK;
            res_first  <= 1'b0;
        end else if (!ena) begin
            rv_q <= 1'b0;
        end else begin
            rv_q       <= 1'b0;
            // A set from CHECK below overrides a same-cycle clear on that channel.
            alert_mask <= alert_mask & ~alert_clr;
            case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        if (state == ACCUM && mon.sample_ch == win_ch) begin
                            acc   <= acc + sample_ext;
                            cnt   <= cnt_inc;
                            state <= (cnt_inc == WIN) ? COMPUTE : ACCUM;
                        end else begin
                            // New window, or channel switch aborting the old one.
                            acc    <= sample_ext;
                            cnt    <= CNT_W'(1);
                            win_ch <= mon.sample_ch;
                            state  <= (WIN == CNT_W'(1)) ? COMPUTE : ACCUM;
                        end
                    end
                end
                COMPUTE: begin
                    avg   <= avg_nxt;
                    dev   <= dev_nxt;
                    state <= CHECK;
                end
                CHECK: begin
                    rv_q    <= 1'b1;
                    res_ch  <= win_ch;
                    res_avg <= avg;
                    if (!base_set[win_ch]) begin
                        baseline[win_ch] <= avg;
                        base_set[win_ch] <= 1'b1;
                        res_lvl          <= LVL_OK;
                        res_first        <= 1'b1;
                    end else begin
                        res_lvl   <= cls_lvl;
                        res_first <= 1'b0;
                        if (cls_lvl != LVL_OK) begin
                            baseline[win_ch]   <= avg;
                            alert_mask[win_ch] <= 1'b1;
                        end
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mon.busy         = (state == COMPUTE) | (state == CHECK);
    assign mon.result_valid = rv_q & ena;
    assign mon.result_ch    = res_ch;
    assign mon.result_avg   = res_avg;
    assign mon.fault_level  = res_lvl;
    assign mon.first_window = res_first;
    assign alert            = |alert_mask;

endmodule

// File: doc/sensor_monitor_multi.md
Name: sensor_monitor_multi

Overview:
- Parametrised successor to the single-stream sensor monitor: N-channel, configurable sample width and averaging depth, runtime-programmable fault thresholds.
- Keeps a per-channel baseline, averages a window of 2^AVG_LOG2 samples, classifies |avg - baseline| into levels 0-4 and keeps a sticky per-channel alert mask that software clears.
- Sits between the sensor-mode input mux and the status/alert outputs of the precision-farming top level.

Parameters:
- NUM_CH, 4, number of sensor channels (≥2); CH_W = $clog2(NUM_CH)
- DATA_W, 8, sample, average and baseline width
- AVG_LOG2, 2, samples per window = 2^AVG_LOG2 (1..6); ACC_W = DATA_W+AVG_LOG2

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- ena  in  1  global enable; low freezes all state
- sample_valid  in  1  sample present this cycle
- sample_data  in  DATA_W  sample value
- sample_ch  in  CH_W  channel of sample
- thr1..thr4  in  DATA_W each  level 1..4 deviation thresholds (quasi-static)
- alert_clr  in  NUM_CH  per-channel sticky-alert clear, pulse
- busy  out  1  high in COMPUTE/CHECK; samples ignored
- result_valid  out  1  one-cycle pulse per completed window
- result_ch  out  CH_W  channel of result
- result_avg  out  DATA_W  window average
- fault_level  out  3  0=OK, 1..4 severity
- first_window  out  1  result was the baseline-setting window
- alert_mask  out  NUM_CH  sticky alert per channel
- alert  out  1  OR of alert_mask

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE; acc, count, all baselines 0; all baseline_set 0; every output 0.
- ena=0: no state changes at all; result_valid forced 0. Resume exactly where frozen.
- FSM IDLE→ACCUM→COMPUTE→CHECK→IDLE. Accept = ena & sample_valid & state∈{IDLE,ACCUM}.
- IDLE: on accept, acc<=sample_data (zero-extended to ACC_W), cnt<=1, win_ch<=sample_ch, →ACCUM.
- ACCUM: on accept with sample_ch==win_ch: acc+=sample, cnt+=1. When the accepted sample is number 2^AVG_LOG2, →COMPUTE. AVG_LOG2 small enough that the window completes in IDLE (only when 2^AVG_LOG2=1) goes IDLE→COMPUTE directly.
- Channel change mid-window (accept with sample_ch≠win_ch): window aborted with no result; restart with this sample as sample 1 of the new channel.
- COMPUTE: avg<=acc>>AVG_LOG2 (truncate); dev<=|avg - baseline[win_ch]| (DATA_W, unsigned). Registered, so CHECK uses the current deviation.
- CHECK: result_valid=1, result_ch=win_ch, result_avg=avg.
  - If !baseline_set[ch]: baseline<=avg, set<=1, fault_level=0, first_window=1.
  - Otherwise the level is the highest k with dev≥thrk, checked from 4 down to 1. Non-monotonic thresholds: highest matching k wins. thr1=0 makes every result at least level 1.
  - If level>0: baseline[ch]<=avg and alert_mask[ch]<=1. If level 0, the baseline is unchanged.
  - →IDLE.
- Latency: the last sample is accepted at edge t; result_valid is high in the cycle after edge t+2. Minimum spacing between windows is 2^AVG_LOG2+2 cycles.
- fault_level, result_ch, result_avg, first_window hold until the next CHECK. result_valid is a single cycle.
- alert_clr[i] clears alert_mask[i] in any state when ena=1. A set from CHECK and a clear on the same channel in the same cycle: set wins.
- Reset mid-window: the partial window is discarded, baselines are lost and the channel must re-learn.

Decomposition:
- Package sensor_mon_pkg: state enum (IDLE, ACCUM, COMPUTE, CHECK); LVL_OK..LVL_4 constants; function for CH_W.
- Sub-module fault_classifier: combinational; dev plus thr1..4 → 3-bit level. Reused by the camera-mode health checks.
- Baseline storage is a NUM_CH×DATA_W register array inside the top, not a RAM.

Test Plan (NUM_CH=4, DATA_W=8, AVG_LOG2=2, thr=10/25/50/100):
- 4× ch0 samples=80 back-to-back → result_valid 2 cycles after the 4th sample, result_avg=80, first_window=1, level 0, alert=0.
- Then 4× ch0 {118,120,122,120} → avg 120, dev 40, level 2, alert_mask=0001, alert=1; next window 4×120 → level 0, mask stays 0001.
- ch1 baseline 200, then window {90,90,90,90} → dev 110, level 4, mask bit1 set; ch2 window of 3 samples then a ch3 sample → no result for ch2; ch3 window completes normally.
- alert_clr=0001 pulsed in the same cycle as a CHECK that raises ch0 level 1 → mask bit0 stays 1; alert_clr=0001 alone later → bit0 cleared, alert follows.
- ena low for 5 cycles mid-window (2 samples in) with sample_valid toggling → nothing accumulated; after ena returns, 2 more samples complete the window with the correct average.
- rst_n low 1 cycle during ACCUM after baselines were set → all outputs 0; next ch0 window reports first_window=1.
